// File: rtl/slicel_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader_if
//   Bitstream handshake bundle between the fabric config chain (master) and
//   a slicel configuration loader (slave).
//   cfg_start : begin/restart a load (1-cycle pulse), master -> slave
//   cfg_data  : bitstream word, WORD_W bits,          master -> slave
//   cfg_valid : cfg_data valid,                       master -> slave
//   cfg_ready : loader accepts a word this cycle,     slave  -> master
// ---------------------------------------------------------------------------
interface slicel_cfg_loader_if #(
   parameter int WORD_W = 8
);
   logic              cfg_start;
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (
      output cfg_start,
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_start,
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );
endinterface

// File: rtl/slicel_cfg_loader.sv
// ---------------------------------------------------------------------------
// slicel_cfg_loader
//   Receives a slice bitstream as WORD_W-bit words, assembles it in a shadow
//   register and commits the whole image atomically onto the slicel parallel
//   config buses. The slice is held in config mode (cen=1) until a commit
//   completes.
//
//   Packed image P = {regs, use_cc, mux, luts}; word k fills P[k*WORD_W +: WORD_W].
//   Pad bits of the last word above CFG_TOTAL are dropped.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cfg (slave modport)   : cfg_start / cfg_data / cfg_valid / cfg_ready
//   luts_config_in        : committed LUT configs (NUM_LUTS*CFG_SIZE)
//   inter_lut_mux_config  : committed f7/f8 mux config (MUX_LVLS)
//   config_use_cc         : committed carry-chain enable
//   regs_config_in        : committed register init values (2*NUM_LUTS)
//   cen                   : 1 = slice in config mode, 0 = run
//   cfg_done              : 1 = a valid committed config is present
//   cfg_err               : sticky protocol error (word offered outside a load)
// ---------------------------------------------------------------------------
module slicel_cfg_loader #(
   parameter  int S_XX_BASE = 4,
   parameter  int NUM_LUTS  = 4,
   parameter  int MUX_LVLS  = $clog2(NUM_LUTS),
   parameter  int WORD_W    = 8,
   localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1,
   localparam int LUT_BITS  = NUM_LUTS * CFG_SIZE,
   localparam int CFG_TOTAL = LUT_BITS + MUX_LVLS + 1 + 2 * NUM_LUTS,
   localparam int NUM_WORDS = (CFG_TOTAL + WORD_W - 1) / WORD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   slicel_cfg_loader_if.slave       cfg,
   output logic [LUT_BITS-1:0]      luts_config_in,
   output logic [MUX_LVLS-1:0]      inter_lut_mux_config,
   output logic                     config_use_cc,
   output logic [2*NUM_LUTS-1:0]    regs_config_in,
   output logic                     cen,
   output logic                     cfg_done,
   output logic                     cfg_err
);

   localparam int CNT_W = $clog2(NUM_WORDS + 1);

   localparam int MUX_LSB  = LUT_BITS;
   localparam int CC_BIT   = LUT_BITS + MUX_LVLS;
   localparam int REGS_LSB = LUT_BITS + MUX_LVLS + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMMIT,
      ST_DONE
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic [CFG_TOTAL-1:0]    shadow_reg;
   logic [LUT_BITS-1:0]     luts_reg;
   logic [MUX_LVLS-1:0]     mux_reg;
   logic                    use_cc_reg;
   logic [2*NUM_LUTS-1:0]   regs_reg;
   logic                    cen_reg;
   logic                    done_reg;
   logic                    err_reg;

   logic                    ready_next;
   logic                    accept;
   logic                    commit;
   logic [NUM_WORDS-1:0]    word_sel;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and control strobes. cfg_start wins over everything,
   // including a word offered in the same cycle and a pending commit.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      ready_next = 1'b0;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cfg.cfg_start) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            ready_next = 1'b1;
            if (cfg.cfg_start) begin
               state_next = ST_LOAD;
            end else if (cfg.cfg_valid) begin
               accept = 1'b1;
               if (cnt_reg == CNT_W'(NUM_WORDS - 1)) begin
                  state_next = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: begin
            if (cfg.cfg_start) begin
               state_next = ST_LOAD;
            end else begin
               commit     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (cfg.cfg_start) begin
               state_next = ST_LOAD;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign cfg.cfg_ready = ready_next;

   // ------------------------------------------------------------------
   // Word counter: cleared by any start, advanced per accepted word.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (cfg.cfg_start) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   // One-hot word strobe decoded from the counter.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_sel
         assign word_sel[gi] = accept && (cnt_reg == CNT_W'(gi));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Shadow image. Stored bit by bit so pad bits of the last word simply
   // have no storage; a restart discards any partial image.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_reg <= '0;
      end else if (cfg.cfg_start) begin
         shadow_reg <= '0;
      end else begin
         for (int b = 0; b < CFG_TOTAL; b++) begin
            if (word_sel[b / WORD_W]) begin
               shadow_reg[b] <= cfg.cfg_data[b % WORD_W];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Committed outputs: all fields load together on the COMMIT->DONE edge,
   // so the slice never sees a partially written image.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         luts_reg   <= '0;
         mux_reg    <= '0;
         use_cc_reg <= 1'b0;
         regs_reg   <= '0;
      end else if (commit) begin
         luts_reg   <= shadow_reg[LUT_BITS-1:0];
         mux_reg    <= shadow_reg[MUX_LSB +: MUX_LVLS];
         use_cc_reg <= shadow_reg[CC_BIT];
         regs_reg   <= shadow_reg[REGS_LSB +: 2*NUM_LUTS];
      end
   end

   // Config-mode / done flags: commit releases the slice, any start
   // (relevant in DONE) puts it back into config mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cen_reg  <= 1'b1;
         done_reg <= 1'b0;
      end else if (commit) begin
         cen_reg  <= 1'b0;
         done_reg <= 1'b1;
      end else if (cfg.cfg_start) begin
         cen_reg  <= 1'b1;
         done_reg <= 1'b0;
      end
   end

   // Sticky error: a word offered while no load is in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_reg <= 1'b0;
      end else if (cfg.cfg_start) begin
         err_reg <= 1'b0;
      end else if (cfg.cfg_valid && (state_reg == ST_IDLE || state_reg == ST_DONE)) begin
         err_reg <= 1'b1;
      end
   end

   assign luts_config_in       = luts_reg;
   assign inter_lut_mux_config = mux_reg;
   assign config_use_cc        = use_cc_reg;
   assign regs_config_in       = regs_reg;
   assign cen                  = cen_reg;
   assign cfg_done             = done_reg;
   assign cfg_err              = err_reg;

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_slicel_cfg_loader
//   Self-checking bench for slicel_cfg_loader at default parameters.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_slicel_cfg_loader;

   localparam int WW    = 8;
   localparam int NL    = 4;
   localparam int LUTW  = 132;       // 4 LUTs * 33 bits
   localparam int NW    = 18;        // ceil(143 / 8)
   localparam int IMGW  = NW * WW;   // 144, one pad bit on top

   logic             clk;
   logic             rst_n;
   logic [LUTW-1:0]  luts_config_in;
   logic [1:0]       inter_lut_mux_config;
   logic             config_use_cc;
   logic [2*NL-1:0]  regs_config_in;
   logic             cen;
   logic             cfg_done;
   logic             cfg_err;

   slicel_cfg_loader_if #(.WORD_W(WW)) cfg_bus ();

   slicel_cfg_loader #(
      .S_XX_BASE (4),
      .NUM_LUTS  (NL),
      .WORD_W    (WW)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .cfg                  (cfg_bus),
      .luts_config_in       (luts_config_in),
      .inter_lut_mux_config (inter_lut_mux_config),
      .config_use_cc        (config_use_cc),
      .regs_config_in       (regs_config_in),
      .cen                  (cen),
      .cfg_done             (cfg_done),
      .cfg_err              (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: the image the slice should currently be running.
   logic [LUTW-1:0]  exp_luts;
   logic [1:0]       exp_mux;
   logic             exp_cc;
   logic [2*NL-1:0]  exp_regs;

   typedef struct {
      logic [LUTW-1:0] luts;
      logic [1:0]      mux;
      logic            cc;
      logic [7:0]      regs;
      logic            pad;
      int              mode;       // 0 valid held, 1 valid every other cycle
      logic [7:0]      exp_regs_v;
      logic [1:0]      exp_mux_v;
      logic            exp_cc_v;
      int              exp_ready;  // cycles ready seen high during the load
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end else begin
         $display("[TB] ok   %s = %0h", name, got);
      end
   endtask

   // Bitstream as the config chain would send it: field concatenation, pad on top.
   function automatic logic [IMGW-1:0] make_image(input logic [LUTW-1:0] l, input logic [1:0] m,
                                                  input logic c, input logic [7:0] r, input logic pad);
      return {pad, r, c, m, l};
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic start_pulse(input logic with_valid);
      cfg_bus.cfg_start = 1'b1;
      cfg_bus.cfg_valid = with_valid;
      cfg_bus.cfg_data  = 8'hE7;
      @(negedge clk);
      cfg_bus.cfg_start = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
   endtask

   // Offer n words of img; returns how many cycles ready was high and
   // whether the committed outputs or cen/done moved during the load.
   task automatic send_words(input logic [IMGW-1:0] img, input int n, input int mode,
                             output int ready_cnt, output bit hold_bad);
      int k = 0;
      int guard = 0;
      logic v;
      logic rdy;
      ready_cnt = 0;
      hold_bad  = 1'b0;
      while (k < n && guard < 400) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         cfg_bus.cfg_valid = v;
         cfg_bus.cfg_data  = img[k*WW +: WW];
         rdy = cfg_bus.cfg_ready;
         if (rdy) ready_cnt++;
         if (luts_config_in !== exp_luts || inter_lut_mux_config !== exp_mux ||
             config_use_cc !== exp_cc || regs_config_in !== exp_regs ||
             cen !== 1'b1 || cfg_done !== 1'b0)
            hold_bad = 1'b1;
         @(negedge clk);
         if (v && rdy) k++;
         guard++;
      end
      cfg_bus.cfg_valid = 1'b0;
      if (k < n) check("load_timeout_words", 256'(k), 256'(n));
   endtask

   // Called right after the last word was accepted: one COMMIT cycle, then DONE.
   task automatic commit_check(input string tag, input logic [IMGW-1:0] img);
      check({tag, "_commit_ready"}, 256'(cfg_bus.cfg_ready), 256'(0));
      check({tag, "_commit_done"},  256'(cfg_done), 256'(0));
      check({tag, "_commit_luts_held"}, 256'(luts_config_in), 256'(exp_luts));
      @(negedge clk);
      exp_luts = img[LUTW-1:0];
      exp_mux  = img[LUTW +: 2];
      exp_cc   = img[LUTW + 2];
      exp_regs = img[LUTW + 3 +: 8];
      check({tag, "_luts"}, 256'(luts_config_in), 256'(exp_luts));
      check({tag, "_mux"},  256'(inter_lut_mux_config), 256'(exp_mux));
      check({tag, "_cc"},   256'(config_use_cc), 256'(exp_cc));
      check({tag, "_regs"}, 256'(regs_config_in), 256'(exp_regs));
      check({tag, "_cen"},  256'(cen), 256'(0));
      check({tag, "_done"}, 256'(cfg_done), 256'(1));
      check({tag, "_err"},  256'(cfg_err), 256'(0));
   endtask

   initial begin
      logic [IMGW-1:0] img;
      logic [IMGW-1:0] img2;
      logic [159:0]    rnd;
      int              rc;
      bit              hb;

      vecs[0] = '{luts: '1, mux: 2'b10, cc: 1'b1, regs: 8'hA5, pad: 1'b1, mode: 0,
                  exp_regs_v: 8'hA5, exp_mux_v: 2'b10, exp_cc_v: 1'b1, exp_ready: 18};
      vecs[1] = '{luts: '1, mux: 2'b10, cc: 1'b1, regs: 8'hA5, pad: 1'b0, mode: 1,
                  exp_regs_v: 8'hA5, exp_mux_v: 2'b10, exp_cc_v: 1'b1, exp_ready: 35};
      vecs[2] = '{luts: {4{33'h1_2345_6789}}, mux: 2'b01, cc: 1'b0, regs: 8'h5A, pad: 1'b1, mode: 0,
                  exp_regs_v: 8'h5A, exp_mux_v: 2'b01, exp_cc_v: 1'b0, exp_ready: 18};
      vecs[3] = '{luts: '0, mux: 2'b00, cc: 1'b0, regs: 8'h00, pad: 1'b1, mode: 1,
                  exp_regs_v: 8'h00, exp_mux_v: 2'b00, exp_cc_v: 1'b0, exp_ready: 35};

      exp_luts = '0; exp_mux = '0; exp_cc = 1'b0; exp_regs = '0;
      cfg_bus.cfg_start = 1'b0;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_data  = '0;
      rst_n = 1'b0;

      // ---- 1: reset state after idling ----
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_cen",   256'(cen), 256'(1));
      check("rst_ready", 256'(cfg_bus.cfg_ready), 256'(0));
      check("rst_done",  256'(cfg_done), 256'(0));
      check("rst_err",   256'(cfg_err), 256'(0));
      check("rst_cfg",   256'({regs_config_in, config_use_cc, inter_lut_mux_config, luts_config_in}), 256'(0));

      // ---- 2/3: table-driven full loads ----
      for (int i = 0; i < 4; i++) begin
         img = make_image(vecs[i].luts, vecs[i].mux, vecs[i].cc, vecs[i].regs, vecs[i].pad);
         start_pulse(1'b0);
         send_words(img, NW, vecs[i].mode, rc, hb);
         check($sformatf("vec%0d_ready_cycles", i), 256'(rc), 256'(vecs[i].exp_ready));
         check($sformatf("vec%0d_hold", i), 256'(hb), 256'(0));
         commit_check($sformatf("vec%0d", i), img);
         check($sformatf("vec%0d_tbl_regs", i), 256'(regs_config_in), 256'(vecs[i].exp_regs_v));
         check($sformatf("vec%0d_tbl_mux", i), 256'(inter_lut_mux_config), 256'(vecs[i].exp_mux_v));
         check($sformatf("vec%0d_tbl_cc", i), 256'(config_use_cc), 256'(vecs[i].exp_cc_v));
      end

      // ---- 4: restart mid-load; second start carries a word that must be dropped ----
      img  = make_image('1, 2'b10, 1'b1, 8'hA5, 1'b0);
      img2 = make_image({4{33'h0_F0F0_F0F0}}, 2'b11, 1'b0, 8'h3C, 1'b0);
      start_pulse(1'b0);
      send_words(img, 9, 0, rc, hb);
      check("restart_partial_hold", 256'(hb), 256'(0));
      start_pulse(1'b1);
      send_words(img2, NW, 0, rc, hb);
      check("restart_hold", 256'(hb), 256'(0));
      commit_check("restart", img2);

      // ---- 5: stray word in DONE ----
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_data  = 8'h77;
      @(negedge clk);
      cfg_bus.cfg_valid = 1'b0;
      check("err_set", 256'(cfg_err), 256'(1));
      repeat (3) @(negedge clk);
      check("err_sticky", 256'(cfg_err), 256'(1));
      check("err_cfg_unchanged", 256'(regs_config_in), 256'(exp_regs));
      check("err_cen", 256'(cen), 256'(0));
      start_pulse(1'b0);
      check("err_cleared", 256'(cfg_err), 256'(0));
      check("reload_cen", 256'(cen), 256'(1));
      check("reload_done", 256'(cfg_done), 256'(0));
      check("reload_regs_held", 256'(regs_config_in), 256'(exp_regs));

      // ---- 6: async reset after word 10 ----
      send_words(img, 10, 0, rc, hb);
      rst_n = 1'b0;
      #1;
      exp_luts = '0; exp_mux = '0; exp_cc = 1'b0; exp_regs = '0;
      check("arst_cfg",   256'({regs_config_in, config_use_cc, inter_lut_mux_config, luts_config_in}), 256'(0));
      check("arst_cen",   256'(cen), 256'(1));
      check("arst_ready", 256'(cfg_bus.cfg_ready), 256'(0));
      check("arst_done",  256'(cfg_done), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_pulse(1'b0);
      send_words(img, NW, 0, rc, hb);
      check("post_rst_hold", 256'(hb), 256'(0));
      commit_check("post_rst", img);

      // ---- random loads, random valid gaps, random aborted partial loads ----
      for (int r = 0; r < 12; r++) begin
         rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         img = make_image(rnd[LUTW-1:0], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) begin
            rnd  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            img2 = make_image(rnd[LUTW-1:0], 2'b01, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
            start_pulse(1'b0);
            send_words(img2, $urandom_range(1, NW - 1), 2, rc, hb);
            check($sformatf("rnd%0d_abort_hold", r), 256'(hb), 256'(0));
         end
         start_pulse(1'($urandom_range(0, 1)));
         send_words(img, NW, 2, rc, hb);
         check($sformatf("rnd%0d_hold", r), 256'(hb), 256'(0));
         commit_check($sformatf("rnd%0d", r), img);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
